uart_rx_fifo: RTL

- Receive-side buffer directly downstream of the UART receiver core (the rx path inside apb_uart, which raises rx_valid and consumes READY_to_receive).
- Captures each received character together with its per-character error flag and holds it until the APB read side pops it.
- Generates back-pressure, a sticky overrun flag and a level-threshold interrupt, so software no longer has to service every character before the next stop bit.

---
 rtl/uart_rx_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : first-word fall-through receive buffer with overrun flag and
//                level-threshold interrupt, downstream of the UART rx core.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_err_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_err_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overrun_o,
  input  logic                  clr_overrun_i,
  input  logic [DEPTH_LOG2:0]   thresh_i,
  output logic                  irq_o
);

  localparam int                  C_WORD_W  = DATA_WIDTH + 1;
  localparam logic [DEPTH_LOG2:0] C_DEPTH   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);

  logic [C_WORD_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overrun;
  logic                  r_irq;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovr_set;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic                  w_irq_next;
  logic [C_WORD_W-1:0]   w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  assign w_pop     = rd_ready_i & ~w_empty;
  // A pop in the same cycle frees the slot this push lands in.
  assign w_push    = rx_valid_i & (~w_full | w_pop);
  assign w_ovr_set = rx_valid_i & w_full & ~w_pop;

  always_comb begin
    w_count_next = r_count;
    if (clr_i) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + C_CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - C_CNT_ONE;
    end
  end

  assign w_irq_next = (thresh_i != '0) && (w_count_next >= thresh_i);

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) begin
      r_mem[r_wr_ptr] <= {rx_err_i, rx_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_irq   <= w_irq_next;
      if (clr_i) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        if (w_ovr_set) begin
          r_overrun <= 1'b1;
        end else if (clr_overrun_i) begin
          r_overrun <= 1'b0;
        end
      end
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign rd_data_o  = w_head[DATA_WIDTH-1:0];
  assign rd_err_o   = w_head[DATA_WIDTH];
  assign rd_valid_o = ~w_empty;
  assign rx_ready_o = ~w_full;
  assign count_o    = r_count;
  assign empty_o    = w_empty;
  assign full_o     = w_full;
  assign overrun_o  = r_overrun;
  assign irq_o      = r_irq;

endmodule

`default_nettype wire
